// File: rtl/uart_tx_sequencer_pkg.sv
// Shared types and constants for the UART transmit sequencer and its byte FIFO.
// Holds the FSM state encoding, default widths and the line idle level used for frame padding.
package uart_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam int DEFAULT_FRAME_WIDTH = 10;
  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_FIFO_DEPTH  = 8;

  // Idle/stop level of the line; pads frame bits above the data byte.
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Bundles the user write port and the transmitter handshake of the sequencer.
// The sequencer uses the slave view; user logic plus transmitter (or a bench) use the master view.
interface uart_tx_sequencer_if
  import uart_tx_sequencer_pkg::*;
#(
  parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) ();

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   full;
  logic [LEVEL_W-1:0]     level;
  logic [FRAME_WIDTH-1:0] data_frame;
  logic                   send_en;
  logic                   frame_sent;

  modport master (
    output wr_en,
    output wr_data,
    output frame_sent,
    input  full,
    input  level,
    input  data_frame,
    input  send_en
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  frame_sent,
    output full,
    output level,
    output data_frame,
    output send_en
  );

endinterface

// File: rtl/uart_tx_sequencer_byte_fifo.sv
// Synchronous circular-buffer FIFO with occupancy counter and a registered read port.
// rd_data updates only on an accepted pop, so it doubles as the consumer's holding register.
module uart_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [LEVEL_W-1:0]    level_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  push;
  logic                  pop;

  // A write while full is dropped even if a pop lands in the same cycle.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  assign full    = (level_reg == LEVEL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign rd_data = rd_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level_reg <= level_reg + LEVEL_W'(1);
        2'b01:   level_reg <= level_reg - LEVEL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage and read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    if (pop) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Byte-queueing front end for a shift-register UART transmitter: FIFO, frame builder,
// send_en/frame_sent handshake, inter-frame gap and a sticky timeout watchdog.
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int FRAME_WIDTH    = DEFAULT_FRAME_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                baud_clk,
  input  logic                rst,
  uart_tx_sequencer_if.slave  bus,
  output logic                busy,
  output logic                tx_fault
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  state_t state_reg;
  state_t state_next;
  state_t after_frame;

  logic [CNT_W-1:0]       wd_cnt_reg;
  logic [CNT_W-1:0]       wd_cnt_next;
  logic [GAP_W-1:0]       gap_cnt_reg;
  logic [GAP_W-1:0]       gap_cnt_next;
  logic [FRAME_WIDTH-1:0] data_frame_reg;
  logic [FRAME_WIDTH-1:0] frame_build;
  logic                   send_en_reg;
  logic                   send_en_next;
  logic                   tx_fault_reg;
  logic                   fault_set;
  logic                   load_frame;
  logic                   pop;
  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  hold_byte;

  uart_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (baud_clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (hold_byte),
    .full    (bus.full),
    .empty   (fifo_empty),
    .level   (bus.level)
  );

  // Data byte in the low bits, idle level everywhere above it.
  genvar gi;
  generate
    for (gi = 0; gi < FRAME_WIDTH; gi++) begin : g_frame
      if (gi < DATA_WIDTH) begin : g_data
        assign frame_build[gi] = hold_byte[gi];
      end else begin : g_pad
        assign frame_build[gi] = IDLE_LEVEL;
      end
    end
  endgenerate

  assign after_frame = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  always_comb begin
    state_next   = state_reg;
    wd_cnt_next  = wd_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    send_en_next = 1'b0;
    load_frame   = 1'b0;
    fault_set    = 1'b0;
    pop          = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_frame = 1'b1;
        state_next = ST_REQ;
      end
      ST_REQ: begin
        send_en_next = 1'b1;
        wd_cnt_next  = '0;
        state_next   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_cnt_next  = wd_cnt_reg + CNT_W'(1);
        gap_cnt_next = '0;
        // A completion arriving on the last allowed cycle still counts as success.
        if (bus.frame_sent) begin
          state_next = after_frame;
        end else if (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          fault_set  = 1'b1;
          state_next = after_frame;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      wd_cnt_reg     <= '0;
      gap_cnt_reg    <= '0;
      data_frame_reg <= '1;
      send_en_reg    <= 1'b0;
      tx_fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wd_cnt_reg  <= wd_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      send_en_reg <= send_en_next;
      // Frame is only refreshed in LOAD, so it stays put through the whole handshake.
      if (load_frame) begin
        data_frame_reg <= frame_build;
      end
      if (fault_set) begin
        tx_fault_reg <= 1'b1;
      end
    end
  end

  assign bus.data_frame = data_frame_reg;
  assign bus.send_en    = send_en_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign tx_fault       = tx_fault_reg;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scenario bench for uart_tx_sequencer: expected frames are queued at write time and
// compared whenever send_en is observed; timing/flag checks are made inline per scenario.
module tb_uart_tx_sequencer;
  import uart_tx_sequencer_pkg::*;

  localparam int FW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TO    = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic baud_clk = 1'b0;
  logic rst      = 1'b1;
  logic busy;
  logic tx_fault;

  uart_tx_sequencer_if #(.FRAME_WIDTH(FW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_sequencer #(
    .FRAME_WIDTH    (FW),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .baud_clk (baud_clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .tx_fault (tx_fault)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  logic [FW-1:0] sb_q[$];

  function automatic logic [FW-1:0] frame_of(input logic [DW-1:0] b);
    return {{(FW - DW){1'b1}}, b};
  endfunction

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic write_byte(input logic [DW-1:0] b, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
    if (accept) sb_q.push_back(frame_of(b));
  endtask

  task automatic wait_send(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.send_en === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // Transmitter model: completion pulse sampled on the 11th edge after send_en rose at edge s.
  task automatic respond(input int s);
    while (cyc < s + 10) tick();
    bus.frame_sent = 1'b1;
    tick();
    bus.frame_sent = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    compared += 6;
    if (bus.data_frame !== {FW{1'b1}}) begin mismatched++; $display("FAIL reset_frame: got %h want %h", bus.data_frame, {FW{1'b1}}); end
    if (bus.send_en !== 1'b0) begin mismatched++; $display("FAIL reset_send_en: got %b want 0", bus.send_en); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (bus.full !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %b want 0", bus.full); end
    if (bus.level !== '0) begin mismatched++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    if (tx_fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault: got %b want 0", tx_fault); end
    rst = 1'b0;
    $display("reset: outputs checked after reset");
  endtask

  task automatic test_single();
    logic [FW-1:0] exp_f;
    int s;
    write_byte(8'h47, 1'b1);
    compared += 2;
    if (bus.level !== LW'(1)) begin mismatched++; $display("FAIL single_level_t: got %0d want 1", bus.level); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_t: got %b want 0", busy); end
    tick();
    compared += 2;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_t1: got %b want 1", busy); end
    if (bus.level !== LW'(0)) begin mismatched++; $display("FAIL single_level_t1: got %0d want 0", bus.level); end
    tick();
    exp_f = sb_q.pop_front();
    compared += 3;
    if (exp_f !== 10'b11_0100_0111) begin mismatched++; $display("FAIL single_model_frame: got %b want 1101000111", exp_f); end
    if (bus.data_frame !== exp_f) begin mismatched++; $display("FAIL single_frame_t2: got %b want %b", bus.data_frame, exp_f); end
    if (bus.send_en !== 1'b0) begin mismatched++; $display("FAIL single_send_t2: got %b want 0", bus.send_en); end
    tick();
    s = cyc;
    compared++;
    if (bus.send_en !== 1'b1) begin mismatched++; $display("FAIL single_send_t3: got %b want 1", bus.send_en); end
    tick();
    compared++;
    if (bus.send_en !== 1'b0) begin mismatched++; $display("FAIL single_send_t4: got %b want 0", bus.send_en); end
    respond(s);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_gap: got %b want 1", busy); end
    tick();
    tick();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_end: got %b want 0", busy); end
    $display("single: byte 47 frame %b sent at edge %0d", exp_f, s);
  endtask

  task automatic test_back_to_back();
    int exp_lv[3] = '{1, 1, 2};
    int s, prev;
    bit ok;
    logic [FW-1:0] exp_f;
    for (int i = 0; i < 3; i++) begin
      write_byte(8'(8'h41 + i), 1'b1);
      compared++;
      if (bus.level !== LW'(exp_lv[i])) begin mismatched++; $display("FAIL b2b_level_%0d: got %0d want %0d", i, bus.level, exp_lv[i]); end
    end
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_send(40, s, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL b2b_send_%0d: got no send_en want pulse", k);
      end else begin
        exp_f = sb_q.pop_front();
        compared++;
        if (bus.data_frame !== exp_f) begin mismatched++; $display("FAIL b2b_frame_%0d: got %h want %h", k, bus.data_frame, exp_f); end
        if (k > 0) begin
          compared++;
          if (s - prev !== 16) begin mismatched++; $display("FAIL b2b_spacing_%0d: got %0d want 16", k, s - prev); end
        end
        if (k == 2) begin
          compared++;
          if (bus.level !== LW'(0)) begin mismatched++; $display("FAIL b2b_level_end: got %0d want 0", bus.level); end
        end
        $display("b2b: frame %0d = %h at edge %0d", k, bus.data_frame, s);
        prev = s;
        respond(s);
      end
    end
    wait_idle(20, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL b2b_idle: got busy want idle"); end
  endtask

  task automatic test_full();
    int exp_lv[10] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
    int s0, s;
    bit ok;
    logic [FW-1:0] exp_f;
    s0 = -1;
    for (int i = 0; i < 10; i++) begin
      write_byte(8'(8'hA0 + i), i < 9);
      compared += 2;
      if (bus.level !== LW'(exp_lv[i])) begin mismatched++; $display("FAIL full_level_%0d: got %0d want %0d", i, bus.level, exp_lv[i]); end
      if (bus.full !== (i >= 8)) begin mismatched++; $display("FAIL full_flag_%0d: got %b want %b", i, bus.full, i >= 8); end
      if (i == 3) begin
        s0 = cyc;
        exp_f = sb_q.pop_front();
        compared += 2;
        if (bus.send_en !== 1'b1) begin mismatched++; $display("FAIL full_send_0: got %b want 1", bus.send_en); end
        if (bus.data_frame !== exp_f) begin mismatched++; $display("FAIL full_frame_0: got %h want %h", bus.data_frame, exp_f); end
      end
      $display("full: write %h level %0d full %b", 8'(8'hA0 + i), bus.level, bus.full);
    end
    respond(s0);
    for (int k = 1; k < 9; k++) begin
      wait_send(40, s, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL full_send_%0d: got no send_en want pulse", k);
      end else begin
        exp_f = sb_q.pop_front();
        compared++;
        if (bus.data_frame !== exp_f) begin mismatched++; $display("FAIL full_frame_%0d: got %h want %h", k, bus.data_frame, exp_f); end
        $display("full: drained frame %h at edge %0d", bus.data_frame, s);
        respond(s);
      end
    end
    wait_send(30, s, ok);
    compared++;
    if (ok) begin mismatched++; $display("FAIL full_dropped: got send_en frame %h want none", bus.data_frame); end
  endtask

  task automatic test_timeout();
    int s, s2;
    bit ok;
    logic [FW-1:0] exp_f;
    write_byte(8'h5A, 1'b1);
    write_byte(8'h6B, 1'b1);
    wait_send(10, s, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL to_send_first: got no send_en want pulse");
    end else begin
      exp_f = sb_q.pop_front();
      compared++;
      if (bus.data_frame !== exp_f) begin mismatched++; $display("FAIL to_frame_first: got %h want %h", bus.data_frame, exp_f); end
      while (cyc < s + 63) tick();
      compared++;
      if (tx_fault !== 1'b0) begin mismatched++; $display("FAIL to_fault_early: got %b want 0 at +63", tx_fault); end
      tick();
      compared += 2;
      if (tx_fault !== 1'b1) begin mismatched++; $display("FAIL to_fault_set: got %b want 1 at +64", tx_fault); end
      if (busy !== 1'b1) begin mismatched++; $display("FAIL to_busy_gap: got %b want 1", busy); end
      $display("timeout: fault raised at edge %0d after send_en at %0d", cyc, s);
      wait_send(20, s2, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("FAIL to_send_next: got no send_en want pulse");
      end else begin
        exp_f = sb_q.pop_front();
        compared += 2;
        if (bus.data_frame !== exp_f) begin mismatched++; $display("FAIL to_frame_next: got %h want %h", bus.data_frame, exp_f); end
        if (s2 - s !== 69) begin mismatched++; $display("FAIL to_resend_time: got %0d want 69", s2 - s); end
        respond(s2);
      end
    end
    wait_idle(20, ok);
    compared += 2;
    if (!ok) begin mismatched++; $display("FAIL to_idle: got busy want idle"); end
    if (tx_fault !== 1'b1) begin mismatched++; $display("FAIL to_fault_sticky: got %b want 1", tx_fault); end
  endtask

  task automatic test_reset_mid();
    int s, s2;
    bit ok;
    logic [FW-1:0] exp_f;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (tx_fault !== 1'b0) begin mismatched++; $display("FAIL mid_fault_clear: got %b want 0", tx_fault); end
    sb_q.delete();
    write_byte(8'h10, 1'b1);
    wait_send(10, s, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL mid_send: got no send_en want pulse");
      s = cyc;
    end else begin
      exp_f = sb_q.pop_front();
      compared++;
      if (bus.data_frame !== exp_f) begin mismatched++; $display("FAIL mid_frame: got %h want %h", bus.data_frame, exp_f); end
    end
    for (int i = 1; i < 5; i++) write_byte(8'(8'h10 + i), 1'b1);
    compared++;
    if (bus.level !== LW'(4)) begin mismatched++; $display("FAIL mid_level_q: got %0d want 4", bus.level); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    compared += 4;
    if (bus.level !== LW'(0)) begin mismatched++; $display("FAIL mid_level_rst: got %0d want 0", bus.level); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy_rst: got %b want 0", busy); end
    if (bus.send_en !== 1'b0) begin mismatched++; $display("FAIL mid_send_rst: got %b want 0", bus.send_en); end
    if (bus.data_frame !== {FW{1'b1}}) begin mismatched++; $display("FAIL mid_frame_rst: got %h want %h", bus.data_frame, {FW{1'b1}}); end
    respond(s);
    wait_send(40, s2, ok);
    compared += 2;
    if (ok) begin mismatched++; $display("FAIL mid_no_send: got send_en at edge %0d want none", s2); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy_late: got %b want 0", busy); end
    $display("reset_mid: queue flushed, late frame_sent ignored");
  endtask

  task automatic test_spurious();
    int s, s2;
    bit ok;
    logic [FW-1:0] exp_f;
    bus.frame_sent = 1'b1;
    tick();
    bus.frame_sent = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL spur_idle_busy: got %b want 0", busy); end
    wait_send(10, s2, ok);
    compared++;
    if (ok) begin mismatched++; $display("FAIL spur_idle_send: got send_en at %0d want none", s2); end
    write_byte(8'h99, 1'b1);
    wait_send(10, s, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL spur_send: got no send_en want pulse");
    end else begin
      exp_f = sb_q.pop_front();
      compared++;
      if (bus.data_frame !== exp_f) begin mismatched++; $display("FAIL spur_frame: got %h want %h", bus.data_frame, exp_f); end
      respond(s);
      bus.frame_sent = 1'b1;
      tick();
      bus.frame_sent = 1'b0;
      compared++;
      if (busy !== 1'b1) begin mismatched++; $display("FAIL spur_gap_busy: got %b want 1", busy); end
      tick();
      compared++;
      if (busy !== 1'b0) begin mismatched++; $display("FAIL spur_gap_end: got %b want 0", busy); end
    end
    wait_send(20, s2, ok);
    compared++;
    if (ok) begin mismatched++; $display("FAIL spur_extra_send: got send_en at %0d want none", s2); end
    $display("spurious: frame_sent in IDLE and GAP ignored");
  endtask

  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.frame_sent = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_timeout();
    test_reset_mid();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
